// File: rtl/wb_ram_arb.sv
// rtl/wb_ram_arb.sv - two-master round-robin Wishbone arbiter in front of ram_wb
// Grant is held for a whole cyc; a watchdog aborts stalled strobes with a one-cycle err.
module wb_ram_arb #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,

  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [31:0]   m0_dat_i,
  input  logic [2:0]    m0_cti_i,
  output logic [31:0]   m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,

  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [31:0]   m1_dat_i,
  input  logic [2:0]    m1_cti_i,
  output logic [31:0]   m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,

  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [31:0]   s_dat_o,
  output logic [2:0]    s_cti_o,
  input  logic [31:0]   s_dat_i,
  input  logic          s_ack_i,

  output logic [1:0]    gnt_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = CW'((TIMEOUT > 0) ? TIMEOUT : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          own_cyc;
  logic          stalled;

  assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;

  // Slave side is a pure combinational mux of the owner while in OWN.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_cti_o = '0;
    if (state_q == OWN) begin
      if (owner_q) begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_cti_o = m1_cti_i;
      end else begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_cti_o = m0_cti_i;
      end
    end
  end

  assign stalled = (state_q == OWN) && s_stb_o && !s_ack_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = 1'b0;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          state_d = OWN;
          if (m0_cyc_i && m1_cyc_i) begin
            owner_d = ~last_q;
          end else begin
            owner_d = m1_cyc_i;
          end
          last_d = owner_d;
        end
      end
      OWN: begin
        // A release wins over an abort landing in the same cycle.
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (stalled) begin
          if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
            state_d = DRAIN;
            err_d   = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      DRAIN: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // err_q is only ever set on the OWN->DRAIN edge, so it can never overlap a forwarded ack.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = (state_q == OWN) && !owner_q && s_ack_i;
  assign m1_ack_o = (state_q == OWN) && owner_q && s_ack_i;
  assign m0_err_o = err_q && !owner_q;
  assign m1_err_o = err_q && owner_q;
  assign gnt_o    = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_wb_ram_arb.sv
// tb/tb_wb_ram_arb.sv - directed bench for wb_ram_arb
// Main instance uses TIMEOUT=8 with a small RAM model; a second instance checks TIMEOUT=0.
module tb_wb_ram_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [3:0]  m0_sel = 4'hF;
  logic [31:0] m0_adr = 0, m0_dat = 0;
  logic [2:0]  m0_cti = 0;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0]  m1_sel = 4'hF;
  logic [31:0] m1_adr = 0, m1_dat = 0;
  logic [2:0]  m1_cti = 0;
  logic [31:0] m0_rdat, m1_rdat, s_adr, s_wdat, s_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  gnt;

  wb_ram_arb #(.AW(32), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_cti_i(m0_cti),
    .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_cti_i(m1_cti),
    .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_cti_o(s_cti),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .gnt_o(gnt)
  );

  // RAM model: one wait state per beat, writes land on the acking edge.
  logic [31:0] mem [0:63];
  logic        ack_q, ack_en = 0, ack_force = 0;
  assign s_ack  = ack_q | ack_force;
  assign s_rdat = mem[s_adr[7:2]];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_en & s_cyc & s_stb & ~ack_q;
      if (s_cyc && s_stb && s_we && ack_q && s_sel == 4'hF) mem[s_adr[7:2]] <= s_wdat;
    end
  end

  // TIMEOUT=0 instance, master 1 idle
  logic        t_cyc = 0, t_ack = 0;
  logic [31:0] z_m0_rdat, z_m1_rdat, z_s_adr, z_s_wdat;
  logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err, z_s_cyc, z_s_stb, z_s_we;
  logic [3:0]  z_s_sel;
  logic [2:0]  z_s_cti;
  logic [1:0]  z_gnt;

  wb_ram_arb #(.AW(32), .TIMEOUT(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(t_cyc), .m0_stb_i(t_cyc), .m0_we_i(1'b0), .m0_sel_i(4'hF),
    .m0_adr_i(32'h40), .m0_dat_i(32'h0), .m0_cti_i(3'b000),
    .m0_dat_o(z_m0_rdat), .m0_ack_o(z_m0_ack), .m0_err_o(z_m0_err),
    .m1_cyc_i(1'b0), .m1_stb_i(1'b0), .m1_we_i(1'b0), .m1_sel_i(4'h0),
    .m1_adr_i(32'h0), .m1_dat_i(32'h0), .m1_cti_i(3'b000),
    .m1_dat_o(z_m1_rdat), .m1_ack_o(z_m1_ack), .m1_err_o(z_m1_err),
    .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_we_o(z_s_we), .s_sel_o(z_s_sel),
    .s_adr_o(z_s_adr), .s_dat_o(z_s_wdat), .s_cti_o(z_s_cti),
    .s_dat_i(32'h1234_5678), .s_ack_i(t_ack), .gnt_o(z_gnt)
  );

  int n_run = 0, n_fail = 0;
  int m1_ack_cnt = 0;
  always @(negedge clk) if (m1_ack) m1_ack_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m0_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    m0_cyc = 1; m0_stb = 1; m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = 4'hF; m0_cti = 0;
    lat = -1; rd = 0;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (i == 1) chk("gnt_after_cyc", {30'd0, gnt}, 32'h1);
      if (m0_ack) begin lat = i; rd = m0_rdat; end
    end
    @(posedge clk); #1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
  endtask

  typedef struct packed {
    logic       m0c, m1c, ack;
    logic [1:0] gnt;
    logic       sc, a0, a1;
  } vec_t;
  vec_t vecs [10];

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int lat, beats, idx, err_cnt, err_at, err0;
    logic gnt_ok, got;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_gnt", {30'd0, gnt}, 32'h0);
    chk("rst_s_cyc", {31'd0, s_cyc}, 32'h0);
    chk("rst_s_adr", s_adr, 32'h0);
    chk("rst_acks_errs", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'h0);
    rst_n = 1'b1;

    // tie sequence: m0, m1, m0 with one idle cycle between owners
    for (int v = 0; v < 10; v++) begin
      @(posedge clk); #1;
      m0_cyc = vecs[v].m0c; m0_stb = vecs[v].m0c;
      m1_cyc = vecs[v].m1c; m1_stb = vecs[v].m1c;
      ack_force = vecs[v].ack;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", v), {30'd0, gnt}, {30'd0, vecs[v].gnt});
      chk($sformatf("vec%0d_s_cyc", v), {31'd0, s_cyc}, {31'd0, vecs[v].sc});
      chk($sformatf("vec%0d_m0_ack", v), {31'd0, m0_ack}, {31'd0, vecs[v].a0});
      chk($sformatf("vec%0d_m1_ack", v), {31'd0, m1_ack}, {31'd0, vecs[v].a1});
    end
    @(posedge clk); #1;
    ack_force = 0; ack_en = 1;

    // single write + readback by m0
    m1_ack_cnt = 0;
    m0_xfer(1'b1, 32'h10, 32'hDEADBEEF, rd, lat);
    chk("wr_ack_latency", lat, 32'd2);
    m0_xfer(1'b0, 32'h10, 32'h0, rd, lat);
    chk("rd_ack_latency", lat, 32'd2);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("m1_ack_quiet", m1_ack_cnt, 32'd0);

    // m1 4-beat burst, m0 requests mid-burst and reads the last word
    @(posedge clk); #1;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF;
    beats = 0; gnt_ok = 1;
    for (int b = 0; b < 4; b++) begin
      m1_adr = 32'h20 + 32'(4 * b); m1_dat = 32'hA000_0000 + 32'(b);
      m1_cti = (b == 3) ? 3'b111 : 3'b010;
      if (b == 1) begin m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h2C; end
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (m1_ack) begin
          got = 1; beats++;
          if (gnt != 2'b10 || m0_ack) gnt_ok = 0;
          if (b == 3) chk("burst_eob_cti", {29'd0, s_cti}, 32'h7);
        end
      end
      @(posedge clk); #1;
    end
    chk("burst_beats", beats, 32'd4);
    chk("burst_grant_held", {31'd0, gnt_ok}, 32'h1);
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_cti = 0;
    idx = -1; lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (idx < 0 && gnt == 2'b01) idx = i;
      if (m0_ack) begin lat = i; rd = m0_rdat; end
    end
    chk("switch_latency", idx, 32'd2);
    chk("burst_last_word", rd, 32'hA000_0003);
    @(posedge clk); #1;
    m0_cyc = 0; m0_stb = 0;

    // watchdog abort with TIMEOUT=8
    @(posedge clk); #1;
    ack_en = 0; m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
    err_cnt = 0; err_at = -1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (m0_err) begin err_cnt++; if (err_at < 0) err_at = i; end
      if (m0_err && m0_ack) chk("ack_err_exclusive", 32'h1, 32'h0);
      if (i == 11) begin
        ack_force = 1; #1;
        chk("late_ack_blocked", {31'd0, m0_ack}, 32'h0);
        chk("drain_s_cyc", {31'd0, s_cyc}, 32'h0);
        ack_force = 0;
      end
    end
    chk("wd_err_count", err_cnt, 32'd1);
    chk("wd_err_cycle", err_at, 32'd9);
    @(posedge clk); #1;
    m0_cyc = 0; m0_stb = 0;
    repeat (2) @(negedge clk);
    chk("idle_after_drain", {30'd0, gnt}, 32'h0);
    ack_en = 1;

    // asynchronous reset mid-burst
    @(posedge clk); #1;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_cti = 3'b010; m1_adr = 32'h20;
    repeat (3) @(negedge clk);
    #2 rst_n = 0; #1;
    chk("arst_gnt", {30'd0, gnt}, 32'h0);
    chk("arst_s_ctl", {29'd0, s_cyc, s_stb, s_we}, 32'h0);
    chk("arst_s_adr", s_adr, 32'h0);
    chk("arst_resp", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'h0);
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_cti = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    repeat (2) @(negedge clk);
    chk("tie_after_reset", {30'd0, gnt}, 32'h1);
    @(posedge clk); #1;
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;

    // TIMEOUT=0: long stall never errors, ack still delivered
    @(posedge clk); #1;
    t_cyc = 1; err0 = 0;
    for (int i = 0; i < 202; i++) begin
      @(negedge clk);
      if (z_m0_err) err0++;
    end
    t_ack = 1; #1;
    chk("t0_ack_delivered", {31'd0, z_m0_ack}, 32'h1);
    chk("t0_rdata", z_m0_rdat, 32'h1234_5678);
    chk("t0_no_err", err0, 32'd0);
    @(posedge clk); #1;
    t_ack = 0; t_cyc = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
